// File: rtl/serial_full_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, LSB first, one bit per clock.
// A single full-subtractor cell with a registered borrow; start/busy/done handshake.
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-2:0] work_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    logic             d_d, nb_d, last_d;
    logic [WIDTH-1:0] res_d;

    always_comb begin
        d_d    = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
        nb_d   = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
        // Work register plus the bit just computed: the full result on the last edge.
        res_d  = {d_d, work_q};
        last_d = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            work_q  <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        work_q  <= '0;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
                    br_q   <= nb_d;
                    cnt_q  <= cnt_q + 1'b1;
                    work_q <= res_d[WIDTH-1:1];
                    if (last_d) begin
                        diff_q  <= res_d;
                        bout_q  <= nb_d;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: doc/serial_full_subtractor.md
Name: serial_full_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = a − b − bin, LSB first, one bit per clock.
- Uses a single full-subtractor cell: difference = x^y^br, borrow = (~x&y) | (~(x^y)&br), with a registered borrow between bits.
- Start/busy/done handshake so a controller can issue back-to-back operations.
- Area-lean datapath block that complements the existing combinational adder cells.

Parameters:
- WIDTH, 8, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on a rising edge when the block is idle or in DONE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- bin  input  1  borrow-in; captured on the accepted start edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse: result valid.
- diff  output  WIDTH  result of the last completed operation, held stable.
- bout  output  1  final borrow-out of the last completed operation, held stable.

Behaviour:
- Reset: rst=1 forces state=IDLE immediately (asynchronous). busy=0, done=0, diff=0, bout=0. Internal shift registers, borrow register and bit counter are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch a into a_sh, b into b_sh, bin into br; clear counter and work register; go to RUN.
  - Otherwise hold.
- RUN, each edge:
  - Compute d and nb from a_sh[0], b_sh[0], br.
  - Shift d into the work register from the MSB side.
  - Shift a_sh and b_sh right by 1; br <= nb; counter +1.
  - On the edge processing bit WIDTH−1: copy the work register (including the final d) to diff, write nb to bout, go to DONE.
- DONE: lasts exactly one cycle with done=1.
  - start=1 on the next edge is accepted exactly as in IDLE (back-to-back), going straight to RUN.
  - Otherwise go to IDLE.
- busy = 1 exactly while state=RUN. done = 1 exactly while state=DONE. Both are decoded from registered state, so they are glitch-free.
- Latency: start accepted at edge T0 → RUN for edges T1..T_WIDTH → done=1 in the cycle after edge T_WIDTH. Total: WIDTH+1 cycles from start to done.
- Throughput: one result every WIDTH+1 cycles with start held high continuously.
- diff/bout change only on the final RUN edge. They never show partial results and hold their value through IDLE and the next RUN.
- start while busy=1 is ignored with no effect. a, b and bin may change freely after the accepted edge.
- Arithmetic:
  - diff = (a − b − bin) mod 2^WIDTH.
  - bout = 1 iff a < b + bin (unsigned).
  - Result is two's-complement consistent, so signed interpretation is valid for the caller.
- Reset mid-RUN aborts the operation: no done pulse, diff/bout return to 0.
- Counter width is clog2(WIDTH), with no wrap hazard: termination is on count == WIDTH−1.

Test Plan:
- Basic subtract (WIDTH=8): a=0x5A, b=0x23, bin=0, pulse start → busy for 8 cycles, done pulse on cycle 9, diff=0x37, bout=0.
- Negative result: a=0x10, b=0x20, bin=0 → diff=0xF0, bout=1. Borrow-in wrap: a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
- Equal operands: a=0xFF, b=0xFF, bin=0 → diff=0x00, bout=0. Then a=0x80, b=0x01, bin=1 → diff=0x7E, bout=0.
- Handshake:
  - Pulse start with a=0x09, b=0x04 (result 0x05).
  - During RUN, assert start with a=0x01, b=0x02 → ignored.
  - Holding start=1 with a=0x03, b=0x01 in the DONE cycle → immediate RUN; next done gives diff=0x02.
  - diff stays 0x05 throughout the second RUN.
- Reset mid-operation: assert rst asynchronously (between edges) at RUN bit 4 → busy, done, diff and bout drop to 0 immediately; no done follows. A new start after release completes correctly.
- Random regression: 1000 random a/b/bin at WIDTH=8 and WIDTH=16 → diff and bout match the reference model {bout,diff} = a − b − bin.
